// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, NOP encoding and fetch FSM states
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP = '0;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH x {inst, pc4} circular buffer with flush and combinational head
module prefetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [2*WORD_W-1:0] din,
  output logic [2*WORD_W-1:0] head,
  output logic [AW:0]         count
);
  logic [2*WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  assign head = mem[rp];
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction prefetcher with one outstanding read; PREFETCH_BYPASS_EN forwards acks into an empty queue
module fetch_prefetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              hold,
  output logic              inst_valid,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc4
);
  localparam int AW = $clog2(DEPTH);
  fetch_state_e state, state_n;
  logic [WORD_W-1:0] fetch_pc, req_addr;
  logic [AW:0] count;
  logic [2*WORD_W-1:0] head;
  logic empty, accept, bypass, push, pop;
  assign empty = count == '0;
  assign accept = state == REQ && mem_ack && !redirect;
`ifdef PREFETCH_BYPASS_EN
  assign bypass = accept && empty;
`else
  assign bypass = 1'b0;
`endif
  assign push = accept && !(bypass && !hold);
  assign pop = !empty && !hold && !redirect;
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(redirect),
    .din({mem_rdata, fetch_pc + 1'b1}), .head(head), .count(count)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = (!redirect && count < (AW+1)'(DEPTH)) ? REQ : IDLE;
    else if (state == REQ)
      state_n = mem_ack ? IDLE : redirect ? DRAIN : REQ;
    else
      state_n = mem_ack ? IDLE : DRAIN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= redirect ? redirect_addr : accept ? fetch_pc + 1'b1 : fetch_pc;
      req_addr <= (state == IDLE && state_n == REQ) ? fetch_pc : req_addr;
    end
  // the draining request keeps its old address after fetch_pc has been redirected
  assign mem_req = state != IDLE;
  assign mem_addr = mem_req ? req_addr : '0;
  assign inst_valid = !empty || bypass;
  assign inst = !empty ? head[2*WORD_W-1:WORD_W] : bypass ? mem_rdata : NOP;
  assign inst_pc4 = !empty ? head[WORD_W-1:0] : bypass ? fetch_pc + 1'b1 : '0;
endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, the first word address fetched after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port mem_req, output, 1, instruction-memory read request.
REQ-006 SHALL have port mem_addr, output, 32, word address of the request.
REQ-007 SHALL have port mem_ack, input, 1, read complete; mem_rdata is valid in the same cycle.
REQ-008 SHALL have port mem_rdata, input, 32, instruction word returned by memory.
REQ-009 SHALL have port redirect, input, 1, branch-taken flush (driven by Branch && zero).
REQ-010 SHALL have port redirect_addr, input, 32, branch target word address.
REQ-011 SHALL have port hold, input, 1, stall from the hazard unit; blocks consumption.
REQ-012 SHALL have port inst_valid, output, 1, head entry present.
REQ-013 SHALL have port inst, output, 32, head instruction; 32'h0 (NOP) when inst_valid=0.
REQ-014 SHALL have port inst_pc4, output, 32, head address+1, feeding IF/ID PC4; 32'h0 when inst_valid=0.

Function
REQ-015 SHALL use word addressing: each next fetch address = previous address + 1, wrapping from 32'hFFFFFFFF to 32'h0.
REQ-016 SHALL implement an FSM with states IDLE, REQ and DRAIN.
REQ-017 IDLE->REQ SHALL occur when (count + 1 pending) < DEPTH... restated precisely: when count < DEPTH and redirect=0; this drives mem_req=1 and mem_addr=fetch_pc.
REQ-018 In REQ, mem_req and mem_addr SHALL be held stable until mem_ack; at most one request is outstanding.
REQ-019 On mem_ack in REQ with redirect=0, the block SHALL push {mem_rdata, fetch_pc+1}, increment fetch_pc, and return to IDLE.
REQ-020 An entry SHALL be consumed (popped) in a cycle with inst_valid=1 and hold=0; push and pop may occur in the same cycle.
REQ-021 On redirect, the queue SHALL be emptied and fetch_pc set to redirect_addr at the next edge; inst_valid=0 in the following cycle.
REQ-022 Redirect in REQ without mem_ack SHALL move to DRAIN; DRAIN keeps mem_req=1 with the old address until mem_ack, discards the data, then goes to IDLE.
REQ-023 Redirect coinciding with mem_ack, in REQ or DRAIN, SHALL discard the returning data and go to IDLE.
REQ-024 Redirect SHALL take priority over hold, push and pop in the same cycle.
REQ-025 Without bypass, latency from mem_ack to inst_valid SHALL be 1 cycle.
REQ-026 The full condition (count=DEPTH) SHALL inhibit new requests; the empty condition SHALL force inst_valid=0 and NOP outputs.

Reset
REQ-027 reset=0 SHALL immediately set: state=IDLE, count=0, fetch_pc=RESET_PC, mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc4=0.
REQ-028 Reset asserted mid-request SHALL abandon the request; a late mem_ack after reset release SHALL be ignored unless in REQ.

Configuration
REQ-029 Macro PREFETCH_BYPASS_EN defined: when the queue is empty, redirect=0 and mem_ack=1, mem_rdata/fetch_pc+1 SHALL appear on inst/inst_pc4 with inst_valid=1 in the same cycle, and be consumed without a push if hold=0.
REQ-030 Macro PREFETCH_BYPASS_EN undefined: outputs SHALL come only from registered queue storage (REQ-025).

Structure
REQ-031 Package mips_pkg SHALL hold the NOP constant, the FSM state enum, and the 32-bit word width constant.
REQ-032 Storage SHALL be a sub-module prefetch_fifo (DEPTH entries x 64 bits, with push, pop, flush, count, and a combinational head).

Verification
REQ-033 Reset release with RESET_PC=0 and mem_ack one cycle after mem_req, rdata=32'h20010005 -> first mem_addr=0; one cycle after the ack inst=32'h20010005, inst_pc4=1.
REQ-034 hold=1 constantly, DEPTH=4, immediate acks -> exactly 4 pushes, then mem_req stays 0; releasing hold pops one entry per cycle in order, addresses 0..3.
REQ-035 Redirect to 32'h40 while in REQ with ack delayed 3 cycles -> DRAIN; old data discarded; next mem_addr=32'h40; inst_valid=0 until 32'h40 data returns.
REQ-036 Redirect and mem_ack in the same cycle -> data dropped, queue empty, next mem_addr=redirect_addr.
REQ-037 fetch_pc=32'hFFFFFFFF, ack -> inst_pc4=0, next mem_addr=0.
REQ-038 With PREFETCH_BYPASS_EN and the queue empty, ack with rdata=32'h8C220004 -> inst_valid=1 and inst=32'h8C220004 in the same cycle; count stays 0 when hold=0.
